// File: rtl/store_buffer_if.sv
// Store-buffer port bundle: pipeline store/load requests, memory write port, status.
// master = pipeline/memory side driving requests; slave = the store buffer itself.
interface store_buffer_if;
  logic        st_valid;
  logic [63:0] st_addr;
  logic [63:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [63:0] ld_addr;
  logic        ld_hit;
  logic [63:0] ld_data;
  logic        ld_conflict;
  logic        mem_busy;
  logic        flush;
  logic        mem_write;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        empty;
  logic        flush_done;

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_busy, flush,
    input  st_ready, ld_hit, ld_data, ld_conflict, mem_write, mem_addr, mem_wdata,
           empty, flush_done
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_busy, flush,
    output st_ready, ld_hit, ld_data, ld_conflict, mem_write, mem_addr, mem_wdata,
           empty, flush_done
  );
endinterface

// File: rtl/store_buffer.sv
// In-order store buffer draining one doubleword per cycle to data memory, with load lookup.
// STORE_BUFFER_FWD_EN enables exact-address forwarding; otherwise any overlap is a conflict.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  store_buffer_if.slave   sb
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [63:0]     addr_q [DEPTH];
  logic [63:0]     addr_d [DEPTH];
  logic [63:0]     data_q [DEPTH];
  logic [63:0]     data_d [DEPTH];

  logic            not_empty;
  logic            enq;
  logic            pop;
  logic            ovl;
  logic [PW-1:0]   idx;
`ifdef STORE_BUFFER_FWD_EN
  logic            fwd_hit;
  logic [63:0]     fwd_data;
`endif

  // st_ready is gated by reset_n so it reads 0 while reset is held
  assign not_empty     = (count_q != '0);
  assign sb.st_ready   = reset_n && (count_q < CW'(DEPTH)) && (state_q != FLUSH);
  assign enq           = sb.st_valid && sb.st_ready;
  assign sb.mem_write  = not_empty && !sb.mem_busy;
  assign pop           = sb.mem_write;
  assign sb.mem_addr   = not_empty ? addr_q[head_q] : '0;
  assign sb.mem_wdata  = not_empty ? data_q[head_q] : '0;
  assign sb.empty      = !not_empty;
  assign sb.flush_done = (state_q == FLUSH) && !not_empty;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    vld_d   = vld_q;
    addr_d  = addr_q;
    data_d  = data_q;
    // enq and pop never target the same slot: enq needs count<DEPTH, pop needs count>0
    if (enq) begin
      addr_d[tail_q] = sb.st_addr;
      data_d[tail_q] = sb.st_data;
      vld_d[tail_q]  = 1'b1;
      tail_d         = tail_q + 1'b1;
    end
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + 1'b1;
    end
    case ({enq, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (sb.flush)    state_d = FLUSH;
        else if (enq)    state_d = DRAIN;
      end
      DRAIN: begin
        if (sb.flush)                                      state_d = FLUSH;
        else if (pop && !enq && count_q == CW'(1))         state_d = IDLE;
      end
      FLUSH: begin
        if (!not_empty)  state_d = IDLE;
      end
      default:           state_d = IDLE;
    endcase
  end

  // Walk oldest to youngest so the last exact match seen is the youngest store
  always_comb begin
    ovl = 1'b0;
    idx = head_q;
`ifdef STORE_BUFFER_FWD_EN
    fwd_hit  = 1'b0;
    fwd_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && vld_q[idx]) begin
        if ((addr_q[idx] + 64'd7 >= sb.ld_addr) && (sb.ld_addr + 64'd7 >= addr_q[idx]))
          ovl = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        if (addr_q[idx] == sb.ld_addr) begin
          fwd_hit  = 1'b1;
          fwd_data = data_q[idx];
        end
`endif
      end
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  assign sb.ld_hit      = sb.ld_valid && fwd_hit;
  assign sb.ld_data     = (sb.ld_valid && fwd_hit) ? fwd_data : '0;
  assign sb.ld_conflict = sb.ld_valid && !fwd_hit && ovl;
`else
  assign sb.ld_hit      = 1'b0;
  assign sb.ld_data     = '0;
  assign sb.ld_conflict = sb.ld_valid && ovl;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios then random traffic, all outputs compared
// each cycle against a queue-based model of the buffer contents.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  store_buffer_if sb ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sb      (sb)
  );

  always #5 clk = ~clk;

  // Model: queue of pending stores (front = oldest) plus a flushing flag
  logic [63:0] mq_addr [$];
  logic [63:0] mq_data [$];
  bit          m_flushing = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    mq_addr.delete();
    mq_data.delete();
    m_flushing = 1'b0;
  endtask

  // Sample at negedge and compare every output with the model
  task automatic settle();
    bit          exact, ovl, e_hit, e_conf;
    logic [63:0] e_data, diff;
    int          n;
    @(negedge clk);
    n = mq_addr.size();
    exact = 0; ovl = 0; e_data = '0;
    if (sb.ld_valid) begin
      for (int i = n - 1; i >= 0; i--) begin
        if (mq_addr[i] == sb.ld_addr && !exact) begin
          exact  = 1;
          e_data = mq_data[i];
        end
        diff = (mq_addr[i] > sb.ld_addr) ? mq_addr[i] - sb.ld_addr : sb.ld_addr - mq_addr[i];
        if (diff < 64'd8) ovl = 1;
      end
    end
`ifdef STORE_BUFFER_FWD_EN
    e_hit  = exact;
    e_conf = !exact && ovl;
`else
    e_hit  = 0;
    e_data = '0;
    e_conf = ovl;
`endif
    check("st_ready",    sb.st_ready,   64'(reset_n && n < DEPTH && !m_flushing));
    check("mem_write",   sb.mem_write,  64'(n != 0 && !sb.mem_busy));
    check("mem_addr",    sb.mem_addr,   (n != 0) ? mq_addr[0] : 64'd0);
    check("mem_wdata",   sb.mem_wdata,  (n != 0) ? mq_data[0] : 64'd0);
    check("ld_hit",      sb.ld_hit,     64'(e_hit));
    check("ld_data",     sb.ld_data,    e_data);
    check("ld_conflict", sb.ld_conflict, 64'(e_conf));
    check("empty",       sb.empty,      64'(n == 0));
    check("flush_done",  sb.flush_done, 64'(m_flushing && n == 0));
  endtask

  // Advance the model by one clock edge, then move off the edge for driving
  task automatic tick();
    bit enq, pop, fdone;
    @(posedge clk);
    if (!reset_n) begin
      model_clear();
    end else begin
      enq   = sb.st_valid && (mq_addr.size() < DEPTH) && !m_flushing;
      pop   = (mq_addr.size() != 0) && !sb.mem_busy;
      fdone = m_flushing && (mq_addr.size() == 0);
      if (pop) begin
        void'(mq_addr.pop_front());
        void'(mq_data.pop_front());
      end
      if (enq) begin
        mq_addr.push_back(sb.st_addr);
        mq_data.push_back(sb.st_data);
      end
      if (fdone)                      m_flushing = 1'b0;
      else if (!m_flushing && sb.flush) m_flushing = 1'b1;
    end
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic store(input logic [63:0] a, input logic [63:0] d);
    sb.st_valid = 1'b1;
    sb.st_addr  = a;
    sb.st_data  = d;
    cyc();
    sb.st_valid = 1'b0;
  endtask

  initial begin
    sb.st_valid = 0; sb.st_addr = 0; sb.st_data = 0;
    sb.ld_valid = 0; sb.ld_addr = 0; sb.mem_busy = 0; sb.flush = 0;

    // Reset state
    settle();
    check("rst_st_ready", sb.st_ready, 0);
    check("rst_empty", sb.empty, 1);
    check("rst_mem_write", sb.mem_write, 0);
    tick();
    reset_n = 1'b1;
    cyc();

    // Single store drains the next cycle
    sb.st_valid = 1; sb.st_addr = 64'h10; sb.st_data = 64'hAA;
    settle();
    check("t38_not_visible_empty", sb.empty, 1);
    tick();
    sb.st_valid = 0;
    settle();
    check("t38_mem_write", sb.mem_write, 1);
    check("t38_mem_addr", sb.mem_addr, 64'h10);
    check("t38_mem_wdata", sb.mem_wdata, 64'hAA);
    tick();
    settle();
    check("t38_empty_after", sb.empty, 1);
    tick();

    // Fill while memory busy
    sb.mem_busy = 1;
    for (int i = 0; i < 5; i++) begin
      sb.st_valid = 1; sb.st_addr = 64'h40 + 64'(8 * i); sb.st_data = 64'(i + 1);
      settle();
      if (i == 4) check("t39_full_ready", sb.st_ready, 0);
      tick();
    end
    sb.st_valid = 0;
    settle();
    check("t39_no_write", sb.mem_write, 0);
    tick();
    sb.mem_busy = 0;
    for (int i = 0; i < 5; i++) cyc();

    // Forwarding / conflict
    sb.mem_busy = 1;
    store(64'h20, 64'h1);
    store(64'h20, 64'h2);
    sb.ld_valid = 1; sb.ld_addr = 64'h20;
    settle();
`ifdef STORE_BUFFER_FWD_EN
    check("t40_hit", sb.ld_hit, 1);
    check("t40_data", sb.ld_data, 64'h2);
`else
    check("t40_conflict_exact", sb.ld_conflict, 1);
`endif
    tick();
    sb.ld_addr = 64'h24;
    settle();
    check("t40_conflict", sb.ld_conflict, 1);
    tick();
    sb.ld_valid = 0;
    settle();
    check("t40_idle_conflict", sb.ld_conflict, 0);
    tick();
    sb.mem_busy = 0;
    for (int i = 0; i < 3; i++) cyc();

    // Flush with three entries
    sb.mem_busy = 1;
    for (int i = 0; i < 3; i++) store(64'h300 + 64'(8 * i), 64'hF0 + 64'(i));
    sb.mem_busy = 0; sb.flush = 1;
    settle();
    check("t41_w0", sb.mem_addr, 64'h300);
    tick();
    sb.st_valid = 1; sb.st_addr = 64'h999; sb.st_data = 64'h5;
    settle();
    check("t41_w1", sb.mem_addr, 64'h308);
    check("t41_rdy1", sb.st_ready, 0);
    tick();
    settle();
    check("t41_w2", sb.mem_addr, 64'h310);
    check("t41_rdy2", sb.st_ready, 0);
    tick();
    sb.flush = 0;
    settle();
    check("t41_done", sb.flush_done, 1);
    check("t41_rdy3", sb.st_ready, 0);
    tick();
    sb.st_valid = 0;
    settle();
    check("t41_done_off", sb.flush_done, 0);
    tick();

    // Flush while empty
    sb.flush = 1;
    cyc();
    sb.flush = 0;
    settle();
    check("t24_done", sb.flush_done, 1);
    tick();
    cyc();

    // Reset while draining
    sb.mem_busy = 1;
    store(64'h500, 64'h11);
    store(64'h508, 64'h22);
    sb.mem_busy = 0;
    reset_n = 0;
    model_clear();
    #1;
    check("t42_empty", sb.empty, 1);
    check("t42_no_write", sb.mem_write, 0);
    cyc();
    reset_n = 1;
    for (int i = 0; i < 3; i++) cyc();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      reset_n     = ($urandom_range(0, 199) != 0);
      if (!reset_n) model_clear();
      sb.st_valid = $urandom_range(0, 1);
      sb.st_addr  = ($urandom_range(0, 9) == 0) ? 64'hFFFF_0000 : 64'h1000 + 64'(4 * $urandom_range(0, 7));
      sb.st_data  = {$urandom, $urandom};
      sb.ld_valid = ($urandom_range(0, 4) < 3);
      sb.ld_addr  = 64'h1000 + 64'(4 * $urandom_range(0, 9));
      sb.mem_busy = ($urandom_range(0, 4) < 2);
      sb.flush    = ($urandom_range(0, 19) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
